// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame deframer with timeout, show-ahead FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise parity is ignored.
module ps2_rx_fifo #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          frame_err
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BIT_W = 4;

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_BYPASS = 1'b0;
`else
   localparam logic PARITY_BYPASS = 1'b1;
`endif

   typedef enum logic {
      IDLE,
      RECV
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   ps2_clk_s;
   logic                   ps2_data_s;
   logic                   sampling;

   state_t             state_q, state_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [10:0]        shift_q, shift_d;
   logic [10:0]        frame_bits;
   logic               frame_done;
   logic               frame_abort;

   logic               start_ok;
   logic               stop_ok;
   logic               parity_ok;
   logic               good_frame;
   logic               bad_frame;
   logic [7:0]         push_data;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_d, wr_d;
   logic [CNT_W-1:0]   count_d, remaining;
   logic               pop;
   logic               push_ok;
   logic               drop;
   logic [7:0]         head_d;

   // Pin synchronisers; idle-high reset so release of reset never looks like a falling edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
   assign ps2_data_s = data_sync[SYNC_STAGES-1];
   assign sampling   = clk_prev & ~ps2_clk_s;

   // Deframer state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         timer_q   <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
      end
   end

   // Deframer next state; frame_bits includes the bit arriving this cycle
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      timer_d     = timer_q;
      shift_d     = shift_q;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      frame_bits  = shift_q;
      frame_bits[bit_cnt_q] = ps2_data_s;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            timer_d   = '0;
            if (sampling) begin
               shift_d    = shift_q;
               shift_d[0] = ps2_data_s;
               bit_cnt_d  = BIT_W'(1);
               state_d    = RECV;
            end
         end
         RECV: begin
            if (sampling) begin
               timer_d = '0;
               shift_d = frame_bits;
               if (bit_cnt_q == BIT_W'(10)) begin
                  frame_done = 1'b1;
                  bit_cnt_d  = '0;
                  state_d    = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES)) begin
               frame_abort = 1'b1;
               bit_cnt_d   = '0;
               timer_d     = '0;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            timer_d   = '0;
         end
      endcase
   end

   assign start_ok   = ~frame_bits[0];
   assign stop_ok    = frame_bits[10];
   assign parity_ok  = (^frame_bits[9:1]) | PARITY_BYPASS;
   assign good_frame = frame_done & start_ok & stop_ok & parity_ok;
   assign bad_frame  = frame_done & ~(start_ok & stop_ok & parity_ok);
   assign push_data  = frame_bits[8:1];

   // FIFO control; a pop in the same cycle makes room for a push into a full FIFO
   always_comb begin
      pop       = data_valid & data_ready;
      push_ok   = good_frame & ((fifo_count < CNT_W'(FIFO_DEPTH)) | pop);
      drop      = good_frame & ~push_ok;
      rd_d      = rd_ptr + PTR_W'(pop);
      wr_d      = wr_ptr + PTR_W'(push_ok);
      count_d   = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
      remaining = fifo_count - CNT_W'(pop);
      head_d    = 8'h00;
      if (remaining != '0) begin
         head_d = mem[rd_d];
      end else if (push_ok) begin
         head_d = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Registered head, status and error outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         data_valid <= 1'b0;
         data_out   <= 8'h00;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rd_ptr     <= rd_d;
         wr_ptr     <= wr_d;
         fifo_count <= count_d;
         data_valid <= (count_d != '0);
         data_out   <= head_d;
         frame_err  <= bad_frame | frame_abort;
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table, directed corner sequences, random frames vs queue model.
module tb_ps2_rx_fifo;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned SYNC    = 2;
   localparam int unsigned TIMEOUT = 200;
   localparam int unsigned HALF    = 16;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b0;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       clr_overflow = 1'b0;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;

   logic [7:0] model_q[$];
   bit         model_ovf;

   ps2_rx_fifo #(
      .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(SYNC),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .data_out(data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .clr_overflow(clr_overflow),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && frame_err) err_cnt++;
   end

   typedef struct {
      logic [7:0] code;
      logic       start;
      logic       par_flip;
      logic       stop;
      logic       exp_push;
      logic       exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] code, input logic start,
                                      input logic par_flip, input logic stop);
      return {stop, (~^code) ^ par_flip, code, start};
   endfunction

   function automatic bit is_good(input logic [10:0] f);
      return (f[0] == 1'b0) && (f[10] == 1'b1) && (!PAR_CHK || (^f[9:1] == 1'b1));
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         cyc(HALF);
         ps2_clk = 1'b0;
         cyc(HALF);
         ps2_clk = 1'b1;
      end
      cyc(HALF);
   endtask

   // Sends a full frame with data_ready low and updates the model
   task automatic send_model(input logic [10:0] f);
      send_bits(f, 11);
      if (is_good(f)) begin
         if (model_q.size() < DEPTH) model_q.push_back(f[8:1]);
         else model_ovf = 1'b1;
      end
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] req);
      @(negedge clk);
      chk({nm, "_valid"}, 32'(data_valid), 32'd1);
      chk({nm, "_data"}, 32'(data_out), 32'(req));
      data_ready = 1'b1;
      cyc(1);
      data_ready = 1'b0;
   endtask

   task automatic drain_model(input string nm);
      while (model_q.size() > 0) pop_chk(nm, model_q.pop_front());
      @(negedge clk);
      chk({nm, "_empty_cnt"}, 32'(fifo_count), 32'd0);
      chk({nm, "_empty_valid"}, 32'(data_valid), 32'd0);
   endtask

   task automatic clear_ovf();
      clr_overflow = 1'b1;
      cyc(1);
      clr_overflow = 1'b0;
      model_ovf = 1'b0;
   endtask

   initial begin
      int e0;
      logic [10:0] f;

      vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, !PAR_CHK, PAR_CHK};
      vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h3A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      cyc(3);
      @(negedge clk);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      reset = 1'b0;
      cyc(5);

      // Single frame 0x1C, then a one-cycle pop
      e0 = err_cnt;
      send_bits(11'b1_0_00011100_0, 11);
      @(negedge clk);
      chk("single_valid", 32'(data_valid), 32'd1);
      chk("single_data", 32'(data_out), 32'h1C);
      chk("single_count", 32'(fifo_count), 32'd1);
      chk("single_noerr", 32'(err_cnt - e0), 32'd0);
      data_ready = 1'b1;
      cyc(1);
      data_ready = 1'b0;
      @(negedge clk);
      chk("single_pop_valid", 32'(data_valid), 32'd0);
      chk("single_pop_count", 32'(fifo_count), 32'd0);

      // Vector table
      foreach (vecs[i]) begin
         e0 = err_cnt;
         send_bits(mk(vecs[i].code, vecs[i].start, vecs[i].par_flip, vecs[i].stop), 11);
         @(negedge clk);
         chk($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_push));
         if (vecs[i].exp_push) pop_chk($sformatf("vec%0d_pop", i), vecs[i].code);
      end

      // Overflow: five frames into a depth-4 FIFO
      e0 = err_cnt;
      for (int i = 1; i <= 5; i++) send_model(mk(8'(i), 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      chk("ovf_count", 32'(fifo_count), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head", 32'(data_out), 32'h01);
      chk("ovf_noerr", 32'(err_cnt - e0), 32'd0);
      clear_ovf();
      @(negedge clk);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      drain_model("ovf_drain");

      // Full FIFO with a pop in the cycle the fifth frame is written
      for (int i = 1; i <= 4; i++) send_bits(mk(8'(i), 1'b0, 1'b0, 1'b1), 11);
      f = mk(8'h05, 1'b0, 1'b0, 1'b1);
      send_bits(f, 10);
      ps2_data = f[10];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(SYNC);
      data_ready = 1'b1;
      cyc(1);
      data_ready = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
      cyc(HALF);
      @(negedge clk);
      chk("fullpop_count", 32'(fifo_count), 32'd4);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      for (int i = 2; i <= 5; i++) pop_chk($sformatf("fullpop_drain%0d", i), 8'(i));

      // Timeout recovery after a 5-bit partial frame
      e0 = err_cnt;
      send_bits(mk(8'h77, 1'b0, 1'b0, 1'b1), 5);
      cyc(TIMEOUT + 10);
      @(negedge clk);
      chk("tmo_err", 32'(err_cnt - e0), 32'd1);
      chk("tmo_count", 32'(fifo_count), 32'd0);
      e0 = err_cnt;
      send_bits(mk(8'hF0, 1'b0, 1'b0, 1'b1), 11);
      @(negedge clk);
      chk("tmo_next_err", 32'(err_cnt - e0), 32'd0);
      chk("tmo_next_count", 32'(fifo_count), 32'd1);
      pop_chk("tmo_next", 8'hF0);

      // Reset mid-frame with two entries queued
      send_bits(mk(8'h11, 1'b0, 1'b0, 1'b1), 11);
      send_bits(mk(8'h22, 1'b0, 1'b0, 1'b1), 11);
      send_bits(mk(8'h33, 1'b0, 1'b0, 1'b1), 6);
      @(negedge clk);
      chk("prerst_count", 32'(fifo_count), 32'd2);
      reset = 1'b1;
      #2;
      chk("midrst_count", 32'(fifo_count), 32'd0);
      chk("midrst_valid", 32'(data_valid), 32'd0);
      chk("midrst_dout", 32'(data_out), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      chk("midrst_err", 32'(frame_err), 32'd0);
      cyc(3);
      reset = 1'b0;
      cyc(3);
      e0 = err_cnt;
      send_bits(mk(8'h5A, 1'b0, 1'b0, 1'b1), 11);
      @(negedge clk);
      chk("postrst_count", 32'(fifo_count), 32'd1);
      chk("postrst_err", 32'(err_cnt - e0), 32'd0);
      pop_chk("postrst", 8'h5A);
      @(negedge clk);
      chk("postrst_empty", 32'(fifo_count), 32'd0);

      // Random frames against the queue model
      model_q.delete();
      model_ovf = 1'b0;
      for (int n = 0; n < 24; n++) begin
         int kind;
         int npop;
         bit exp_err;
         kind = $urandom_range(0, 9);
         f = mk(8'($urandom), kind == 2, kind == 0, kind != 1);
         exp_err = !is_good(f);
         e0 = err_cnt;
         send_model(f);
         @(negedge clk);
         chk($sformatf("rnd%0d_err", n), 32'(err_cnt - e0), 32'(exp_err));
         chk($sformatf("rnd%0d_count", n), 32'(fifo_count), 32'(model_q.size()));
         chk($sformatf("rnd%0d_ovf", n), 32'(overflow), 32'(model_ovf));
         if (model_ovf) clear_ovf();
         npop = (model_q.size() == 0) ? 0 : $urandom_range(0, model_q.size());
         for (int k = 0; k < npop; k++) pop_chk($sformatf("rnd%0d_pop", n), model_q.pop_front());
      end
      drain_model("rnd_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
